// File: rtl/rvc_decoder_pkg.sv
// rtl/rvc_decoder_pkg.sv - shared internal opcode codes and decode result type for the RVC decoder
package rvc_decoder_pkg;

  localparam logic [7:0] OP_LUI     = 8'h01;
  localparam logic [7:0] OP_ADDI    = 8'h02;
  localparam logic [7:0] OP_SLLI    = 8'h03;
  localparam logic [7:0] OP_SRLI    = 8'h04;
  localparam logic [7:0] OP_SRAI    = 8'h05;
  localparam logic [7:0] OP_ANDI    = 8'h06;
  localparam logic [7:0] OP_ADD     = 8'h07;
  localparam logic [7:0] OP_SUB     = 8'h08;
  localparam logic [7:0] OP_XOR     = 8'h09;
  localparam logic [7:0] OP_OR      = 8'h0A;
  localparam logic [7:0] OP_AND     = 8'h0B;
  localparam logic [7:0] OP_LW      = 8'h0C;
  localparam logic [7:0] OP_SW      = 8'h0D;
  localparam logic [7:0] OP_JAL     = 8'h0E;
  localparam logic [7:0] OP_JALR    = 8'h0F;
  localparam logic [7:0] OP_BEQ     = 8'h10;
  localparam logic [7:0] OP_BNE     = 8'h11;
  localparam logic [7:0] OP_ILLEGAL = 8'hFF;

  typedef enum logic [1:0] {
    Q0     = 2'b00,
    Q1     = 2'b01,
    Q2     = 2'b10,
    Q_BASE = 2'b11
  } quad_e;

  typedef struct packed {
    logic [7:0]  op;
    logic [4:0]  dr;
    logic [4:0]  sr1;
    logic [4:0]  sr2;
    logic [31:0] imm;
    logic        val;
  } decode_t;

endpackage

// File: rtl/rvc_decoder.sv
// rtl/rvc_decoder.sv - RV32C halfword expander with one registered output stage; RVC_STRICT_RESERVED_EN rejects reserved zero forms
module rvc_decoder
  import rvc_decoder_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] com_inst_i,
  output logic [7:0]  com_inst_o,
  output logic [4:0]  com_reg_dr_o,
  output logic [4:0]  com_reg_sr1_o,
  output logic [4:0]  com_reg_sr2_o,
  output logic [31:0] com_imm_data_o,
  output logic        com_inst_val_o
);

`ifdef RVC_STRICT_RESERVED_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  function automatic logic [4:0] creg(input logic [2:0] f);
    return {2'b01, f};
  endfunction

  logic [15:0] w;
  quad_e       quad;
  logic [31:0] imm6;
  logic        ill;
  decode_t     d;

  assign w    = com_inst_i;
  assign quad = quad_e'(w[1:0]);
  assign imm6 = {{26{w[12]}}, w[12], w[6:2]};

  always_comb begin
    d     = '0;
    ill   = 1'b0;
    d.val = (quad != Q_BASE);
    case (quad)
      Q0: begin
        case (w[15:13])
          3'b000: begin
            d.op  = OP_ADDI;
            d.dr  = creg(w[4:2]);
            d.sr1 = 5'd2;
            d.imm = {22'b0, w[10:7], w[12:11], w[5], w[6], 2'b00};
            ill   = (w == 16'h0000) || (STRICT && (w[12:5] == 8'h00));
          end
          3'b010: begin
            d.op  = OP_LW;
            d.dr  = creg(w[4:2]);
            d.sr1 = creg(w[9:7]);
            d.imm = {25'b0, w[5], w[12:10], w[6], 2'b00};
          end
          3'b110: begin
            d.op  = OP_SW;
            d.sr1 = creg(w[9:7]);
            d.sr2 = creg(w[4:2]);
            d.imm = {25'b0, w[5], w[12:10], w[6], 2'b00};
          end
          default: ill = 1'b1;
        endcase
      end
      Q1: begin
        case (w[15:13])
          3'b000: begin
            d.op  = OP_ADDI;
            d.dr  = w[11:7];
            d.sr1 = w[11:7];
            d.imm = imm6;
          end
          3'b001, 3'b101: begin
            d.op  = OP_JAL;
            d.dr  = w[15] ? 5'd0 : 5'd1;
            d.imm = {{21{w[12]}}, w[8], w[10:9], w[6], w[7], w[2], w[11], w[5:3], 1'b0};
          end
          3'b010: begin
            d.op  = OP_ADDI;
            d.dr  = w[11:7];
            d.imm = imm6;
          end
          3'b011: begin
            ill = STRICT && ({w[12], w[6:2]} == 6'd0);
            if (w[11:7] == 5'd2) begin
              d.op  = OP_ADDI;
              d.dr  = 5'd2;
              d.sr1 = 5'd2;
              d.imm = {{23{w[12]}}, w[4:3], w[5], w[2], w[6], 4'b0000};
            end else begin
              d.op  = OP_LUI;
              d.dr  = w[11:7];
              d.imm = {{14{w[12]}}, w[12], w[6:2], 12'h000};
            end
          end
          3'b100: begin
            d.dr  = creg(w[9:7]);
            d.sr1 = creg(w[9:7]);
            case (w[11:10])
              2'b00: begin
                d.op  = OP_SRLI;
                d.imm = {26'b0, w[12], w[6:2]};
                ill   = w[12];
              end
              2'b01: begin
                d.op  = OP_SRAI;
                d.imm = {26'b0, w[12], w[6:2]};
                ill   = w[12];
              end
              2'b10: begin
                d.op  = OP_ANDI;
                d.imm = imm6;
              end
              default: begin
                // w[12]=1 selects the RV64-only word ops
                ill   = w[12];
                d.sr2 = creg(w[4:2]);
                case (w[6:5])
                  2'b00:   d.op = OP_SUB;
                  2'b01:   d.op = OP_XOR;
                  2'b10:   d.op = OP_OR;
                  default: d.op = OP_AND;
                endcase
              end
            endcase
          end
          default: begin
            d.op  = w[13] ? OP_BNE : OP_BEQ;
            d.sr1 = creg(w[9:7]);
            d.imm = {{24{w[12]}}, w[6:5], w[2], w[11:10], w[4:3], 1'b0};
          end
        endcase
      end
      Q2: begin
        case (w[15:13])
          3'b000: begin
            d.op  = OP_SLLI;
            d.dr  = w[11:7];
            d.sr1 = w[11:7];
            d.imm = {26'b0, w[12], w[6:2]};
            ill   = w[12];
          end
          3'b010: begin
            d.op  = OP_LW;
            d.dr  = w[11:7];
            d.sr1 = 5'd2;
            d.imm = {24'b0, w[3:2], w[12], w[6:4], 2'b00};
            ill   = STRICT && (w[11:7] == 5'd0);
          end
          3'b100: begin
            if (!w[12]) begin
              if (w[6:2] == 5'd0) begin
                d.op  = OP_JALR;
                d.sr1 = w[11:7];
                ill   = STRICT && (w[11:7] == 5'd0);
              end else begin
                d.op  = OP_ADD;
                d.dr  = w[11:7];
                d.sr2 = w[6:2];
              end
            end else if (w[6:2] == 5'd0) begin
              // rs1=0 here is C.EBREAK
              ill   = (w[11:7] == 5'd0);
              d.op  = OP_JALR;
              d.dr  = 5'd1;
              d.sr1 = w[11:7];
            end else begin
              d.op  = OP_ADD;
              d.dr  = w[11:7];
              d.sr1 = w[11:7];
              d.sr2 = w[6:2];
            end
          end
          3'b110: begin
            d.op  = OP_SW;
            d.sr1 = 5'd2;
            d.sr2 = w[6:2];
            d.imm = {24'b0, w[8:7], w[12:9], 2'b00};
          end
          default: ill = 1'b1;
        endcase
      end
      default: d = '0;
    endcase
    if (ill) begin
      d     = '0;
      d.op  = OP_ILLEGAL;
      d.val = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      com_inst_o     <= '0;
      com_reg_dr_o   <= '0;
      com_reg_sr1_o  <= '0;
      com_reg_sr2_o  <= '0;
      com_imm_data_o <= '0;
      com_inst_val_o <= 1'b0;
    end else begin
      com_inst_o     <= d.op;
      com_reg_dr_o   <= d.dr;
      com_reg_sr1_o  <= d.sr1;
      com_reg_sr2_o  <= d.sr2;
      com_imm_data_o <= d.imm;
      com_inst_val_o <= d.val;
    end
  end

endmodule

// File: tb/tb_rvc_decoder.sv
// tb/tb_rvc_decoder.sv - scoreboard bench for rvc_decoder against an arithmetic RV32C reference model
module tb_rvc_decoder;
  import rvc_decoder_pkg::*;

`ifdef RVC_STRICT_RESERVED_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  op;
    logic [4:0]  dr;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] imm;
    logic        val;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] inst;
  logic [7:0]  op_o;
  logic [4:0]  dr_o, s1_o, s2_o;
  logic [31:0] imm_o;
  logic        val_o;

  int checks = 0;
  int errors = 0;
  exp_t        exp_q[$];
  logic [15:0] word_q[$];

  rvc_decoder dut (
    .clk_i(clk), .rst_i(rst), .com_inst_i(inst),
    .com_inst_o(op_o), .com_reg_dr_o(dr_o), .com_reg_sr1_o(s1_o),
    .com_reg_sr2_o(s2_o), .com_imm_data_o(imm_o), .com_inst_val_o(val_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int fld(logic [15:0] x, int hi, int lo);
    return int'(32'(x >> lo) & ((32'd1 << (hi - lo + 1)) - 1));
  endfunction

  function automatic int sx(int v, int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  // Reference: field extraction by weight, then the mapping table from the ISA manual
  function automatic exp_t model(logic [15:0] x);
    exp_t r;
    int q, f3, rd, rs2, rdp, rs1p, i6, op, dr, s1, s2, imm;
    bit ill;
    r = '0;
    q = fld(x, 1, 0); f3 = fld(x, 15, 13); rd = fld(x, 11, 7); rs2 = fld(x, 6, 2);
    rdp = 8 + fld(x, 4, 2); rs1p = 8 + fld(x, 9, 7);
    i6 = sx(fld(x, 12, 12) * 32 + rs2, 6);
    op = 0; dr = 0; s1 = 0; s2 = 0; imm = 0; ill = 0;
    if (q == 3) return r;
    if (q == 0) begin
      if (f3 == 0) begin
        imm = fld(x, 12, 11) * 16 + fld(x, 10, 7) * 64 + fld(x, 6, 6) * 4 + fld(x, 5, 5) * 8;
        op = OP_ADDI; dr = rdp; s1 = 2;
        ill = (x == 16'h0) || (STRICT && imm == 0);
      end else if (f3 == 2 || f3 == 6) begin
        imm = fld(x, 12, 10) * 8 + fld(x, 6, 6) * 4 + fld(x, 5, 5) * 64;
        s1 = rs1p;
        if (f3 == 2) begin op = OP_LW; dr = rdp; end
        else begin op = OP_SW; s2 = rdp; end
      end else ill = 1;
    end else if (q == 1) begin
      case (f3)
        0: begin op = OP_ADDI; dr = rd; s1 = rd; imm = i6; end
        1, 5: begin
          op = OP_JAL; dr = (f3 == 1) ? 1 : 0;
          imm = sx(fld(x, 12, 12) * 2048 + fld(x, 11, 11) * 16 + fld(x, 10, 9) * 256 + fld(x, 8, 8) * 1024
                   + fld(x, 7, 7) * 64 + fld(x, 6, 6) * 128 + fld(x, 5, 3) * 2 + fld(x, 2, 2) * 32, 12);
        end
        2: begin op = OP_ADDI; dr = rd; imm = i6; end
        3: begin
          ill = STRICT && (i6 == 0);
          if (rd == 2) begin
            op = OP_ADDI; dr = 2; s1 = 2;
            imm = sx(fld(x, 12, 12) * 512 + fld(x, 6, 6) * 16 + fld(x, 5, 5) * 64 + fld(x, 4, 3) * 128
                     + fld(x, 2, 2) * 32, 10);
          end else begin op = OP_LUI; dr = rd; imm = i6 * 4096; end
        end
        4: begin
          dr = rs1p; s1 = rs1p;
          case (fld(x, 11, 10))
            0: begin op = OP_SRLI; imm = fld(x, 12, 12) * 32 + rs2; ill = fld(x, 12, 12) == 1; end
            1: begin op = OP_SRAI; imm = fld(x, 12, 12) * 32 + rs2; ill = fld(x, 12, 12) == 1; end
            2: begin op = OP_ANDI; imm = i6; end
            default: begin
              ill = fld(x, 12, 12) == 1; s2 = rdp;
              case (fld(x, 6, 5))
                0: op = OP_SUB;
                1: op = OP_XOR;
                2: op = OP_OR;
                default: op = OP_AND;
              endcase
            end
          endcase
        end
        default: begin
          op = (f3 == 6) ? OP_BEQ : OP_BNE; s1 = rs1p;
          imm = sx(fld(x, 12, 12) * 256 + fld(x, 11, 10) * 8 + fld(x, 6, 5) * 64 + fld(x, 4, 3) * 2
                   + fld(x, 2, 2) * 32, 9);
        end
      endcase
    end else begin
      case (f3)
        0: begin op = OP_SLLI; dr = rd; s1 = rd; imm = fld(x, 12, 12) * 32 + rs2; ill = fld(x, 12, 12) == 1; end
        2: begin
          op = OP_LW; dr = rd; s1 = 2; ill = STRICT && rd == 0;
          imm = fld(x, 12, 12) * 32 + fld(x, 6, 4) * 4 + fld(x, 3, 2) * 64;
        end
        4: begin
          if (fld(x, 12, 12) == 0) begin
            if (rs2 == 0) begin op = OP_JALR; s1 = rd; ill = STRICT && rd == 0; end
            else begin op = OP_ADD; dr = rd; s2 = rs2; end
          end else if (rs2 == 0) begin
            op = OP_JALR; dr = 1; s1 = rd; ill = (rd == 0);
          end else begin op = OP_ADD; dr = rd; s1 = rd; s2 = rs2; end
        end
        6: begin op = OP_SW; s1 = 2; s2 = rs2; imm = fld(x, 12, 9) * 4 + fld(x, 8, 7) * 64; end
        default: ill = 1;
      endcase
    end
    r.val = 1'b1;
    if (ill) begin
      r.op = OP_ILLEGAL;
    end else begin
      r.op = 8'(op); r.dr = 5'(dr); r.s1 = 5'(s1); r.s2 = 5'(s2); r.imm = 32'(imm);
    end
    return r;
  endfunction

  function automatic exp_t got();
    return {op_o, dr_o, s1_o, s2_o, imm_o, val_o};
  endfunction

  task automatic check_zero(input string name);
    exp_t g;
    g = got();
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL %s: got %h required 0", name, g);
    end
  endtask

  task automatic issue(input logic [15:0] x);
    inst = x;
    exp_q.push_back(model(x));
    word_q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: one result is due just after each capturing edge
  always @(posedge clk) begin
    #1;
    if (rst && exp_q.size() > 0) begin
      exp_t e, g;
      logic [15:0] x;
      e = exp_q.pop_front();
      x = word_q.pop_front();
      g = got();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL decode inst=%h: got op=%h dr=%0d sr1=%0d sr2=%0d imm=%h val=%b required op=%h dr=%0d sr1=%0d sr2=%0d imm=%h val=%b",
                 x, g.op, g.dr, g.s1, g.s2, g.imm, g.val, e.op, e.dr, e.s1, e.s2, e.imm, e.val);
      end
    end
  end

  logic [15:0] directed [16] = '{
    16'h4501, 16'h4188, 16'h852E, 16'h8082, 16'h0000, 16'h0013, 16'h0004, 16'h6101,
    16'h4002, 16'h8002, 16'h9002, 16'h1082, 16'h9082, 16'hFFFD, 16'hC04C, 16'h7101
  };

  initial begin
    rst  = 1'b0;
    inst = 16'h0;
    for (int i = 0; i < 4; i++) begin
      inst = 16'($urandom);
      @(negedge clk);
      check_zero("reset_hold");
    end
    rst = 1'b1;
    for (int i = 0; i < 16; i++) issue(directed[i]);
    for (int i = 0; i < 400; i++) issue(16'($urandom));
    // Async reset mid-cycle with a live non-zero result on the outputs
    inst = 16'h4188;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    inst = 16'h852E;
    @(negedge clk);
    check_zero("reset_after_edge");
    rst = 1'b1;
    for (int i = 0; i < 100; i++) issue(16'($urandom));
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
